reaction_timer_core: RTL
========================

// Module: reaction_timer_core
// PURPOSE
//  Reaction-timer control stage fed by the button debouncer's level output.
//  - Detects the press edge and waits a pseudo-random delay before lighting the stimulus LED.
//  - Measures the time from LED-on to the next press in milliseconds and reports it.
//  - Flags a press before the LED as a false start and tracks the best time.
//  - Its outputs feed the display/BCD stage.
// PARAMETERS
//  CLKS_PER_MS   100000   clk cycles per 1 ms tick (100 MHz clk)
//  MIN_DELAY_MS  1000     fixed part of the pre-stimulus delay, ms
//  RAND_BITS     11       random part of the delay = lfsr[RAND_BITS-1:0], 0..2^RAND_BITS-1 ms
//  MAX_MS        9999     reaction time saturation/timeout value, ms
//  LFSR_SEED     16'hACE1 LFSR reset value; must be non-zero
// PORTS
//  clk              in   1   system clock
//  reset            in   1   synchronous, active-high reset
//  debouncedButton  in   1   debounced button level, 1 = pressed
//  stimulusLed      out  1   1 while waiting for the reaction (ARMED)
//  reactionTime     out  14  last measured time, ms, held until the next result
//  resultValid      out  1   one-cycle pulse when reactionTime is updated
//  falseStart       out  1   held high in FALSE_START state
//  bestTime         out  14  minimum reactionTime since reset
//  busy             out  1   1 in WAIT or ARMED
// BEHAVIOUR
//  - Reset values: state=IDLE, stimulusLed=0, reactionTime=0, resultValid=0, falseStart=0,
//    bestTime=MAX_MS, msCount=0, lfsr=LFSR_SEED, prevButton=1.
//  - prevButton=1 at reset means a button held through reset is not a press.
//  - press = debouncedButton & ~prevButton; prevButton is registered every cycle.
//    A held button gives exactly one press.
//  - lfsr: 16-bit Fibonacci, taps 16,14,13,11, advances every cycle. If it is ever 0, reload LFSR_SEED.
//  - msTick: prescaler counts 0..CLKS_PER_MS-1 and pulses for one cycle at terminal count.
//    The prescaler and msCount clear on every entry to WAIT or ARMED.
//  - FSM:
//    IDLE --press--> WAIT; load delayTarget = MIN_DELAY_MS + lfsr[RAND_BITS-1:0].
//    WAIT: msCount++ on msTick.
//      press --> FALSE_START (press has priority over reaching the target).
//      msCount==delayTarget --> ARMED; stimulusLed=1 from the next cycle.
//    ARMED: msCount++ on msTick.
//      press --> DONE; reactionTime=msCount before increment (press beats a same-cycle tick).
//      msCount==MAX_MS with no press --> DONE; reactionTime=MAX_MS (timeout).
//      resultValid pulses in the cycle DONE is entered.
//      bestTime=reactionTime on that cycle only if the new value is smaller (timeouts included).
//    DONE / FALSE_START: outputs held.
//      press --> WAIT with a new delayTarget; falseStart clears on exit.
//  - Widths: msCount, delayTarget and the time regs are 14 bits.
//    Elaboration must error if MIN_DELAY_MS+2^RAND_BITS-1 > 16383 or MAX_MS > 16383.
//  - Reset mid-round: returns to IDLE next cycle; LED off; bestTime lost.
// TESTING  (sim params: CLKS_PER_MS=4, MIN_DELAY_MS=3, RAND_BITS=2, MAX_MS=20)
//  1. reset with button high, then release -> no press; state stays IDLE, busy=0.
//  2. Press in IDLE, delay d=3+lfsr[1:0], press 5 ticks after LED rises -> reactionTime=5, one resultValid pulse, bestTime=5.
//  3. Press during WAIT at tick 1 -> falseStart=1, stimulusLed never asserted, reactionTime unchanged.
//  4. No press after LED -> DONE at msCount=20, reactionTime=20, bestTime keeps prior 5.
//  5. Press coincident with msTick at msCount=7 in ARMED -> reactionTime=7, not 8.
//  6. Button held high over 50 cycles in DONE -> one new round only; reset asserted in ARMED -> LED=0, IDLE next cycle.

Source files
------------

// File: rtl/reaction_timer_core_if.sv
// Signal bundle between the reaction-timer core and its neighbours:
// the debounced button level in, stimulus/result/status lines out.
interface reaction_timer_core_if;
  logic        debouncedButton;
  logic        stimulusLed;
  logic [13:0] reactionTime;
  logic        resultValid;
  logic        falseStart;
  logic [13:0] bestTime;
  logic        busy;

  // Button/debouncer side: drives the button, observes the results.
  modport master (
    output debouncedButton,
    input  stimulusLed,
    input  reactionTime,
    input  resultValid,
    input  falseStart,
    input  bestTime,
    input  busy
  );

  // Timer core side.
  modport slave (
    input  debouncedButton,
    output stimulusLed,
    output reactionTime,
    output resultValid,
    output falseStart,
    output bestTime,
    output busy
  );
endinterface

// File: rtl/reaction_timer_core.sv
// Reaction-timer control stage. A button press starts a round: after a
// pseudo-random delay the stimulus LED lights, and the time to the next press
// is measured in milliseconds. A press before the LED is a false start.
// The best (smallest) result since reset is tracked.
module reaction_timer_core #(
  parameter int          CLKS_PER_MS  = 100000,
  parameter int          MIN_DELAY_MS = 1000,
  parameter int          RAND_BITS    = 11,
  parameter int          MAX_MS       = 9999,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input logic                  clk,
  input logic                  reset,
  reaction_timer_core_if.slave bus
);

  localparam int PW = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLKS_PER_MS - 1);
  localparam logic [13:0]   MIN_DELAY  = 14'(MIN_DELAY_MS);
  localparam logic [13:0]   MAX_TIME   = 14'(MAX_MS);

  // Refuse to elaborate with parameters that do not fit the 14-bit time path.
  if (MIN_DELAY_MS + (1 << RAND_BITS) - 1 > 16383) begin : g_bad_delay
    $error("reaction_timer_core: MIN_DELAY_MS + 2^RAND_BITS - 1 exceeds 16383");
  end
  if (MAX_MS > 16383) begin : g_bad_max
    $error("reaction_timer_core: MAX_MS exceeds 16383");
  end
  if (RAND_BITS < 1 || RAND_BITS > 14) begin : g_bad_rand
    $error("reaction_timer_core: RAND_BITS must be 1..14");
  end
  if (LFSR_SEED == 16'h0000) begin : g_bad_seed
    $error("reaction_timer_core: LFSR_SEED must be non-zero");
  end
  if (CLKS_PER_MS < 1) begin : g_bad_clks
    $error("reaction_timer_core: CLKS_PER_MS must be at least 1");
  end

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ARMED,
    ST_DONE,
    ST_FALSE_START
  } state_t;

  state_t         state_reg, state_next;
  logic           prev_button_reg;
  logic [15:0]    lfsr_reg;
  logic [15:0]    lfsr_shift;
  logic           lfsr_fb;
  logic [PW-1:0]  presc_reg;
  logic [13:0]    ms_count_reg, ms_count_next;
  logic [13:0]    delay_target_reg, delay_target_next;
  logic [13:0]    reaction_time_reg, reaction_time_next;
  logic [13:0]    best_time_reg, best_time_next;
  logic           result_valid_reg, result_valid_next;
  logic           clear_counters;
  logic           finish;
  logic [13:0]    finish_time;
  logic           press;
  logic           ms_tick;
  logic [13:0]    new_target;

  // A press is the rising edge of the debounced level; prev starts high so a
  // button held through reset does not count.
  assign press   = bus.debouncedButton & ~prev_button_reg;
  assign ms_tick = (presc_reg == PRESC_LAST);

  // Fibonacci LFSR, taps 16,14,13,11, shifting towards the MSB.
  assign lfsr_fb       = lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10];
  assign lfsr_shift[0] = lfsr_fb;
  for (genvar gi = 1; gi < 16; gi++) begin : g_lfsr_shift
    assign lfsr_shift[gi] = lfsr_reg[gi-1];
  end

  assign new_target = MIN_DELAY + 14'(lfsr_reg[RAND_BITS-1:0]);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic and the values captured on each transition.
  always_comb begin
    state_next         = state_reg;
    ms_count_next      = ms_count_reg;
    delay_target_next  = delay_target_reg;
    reaction_time_next = reaction_time_reg;
    best_time_next     = best_time_reg;
    result_valid_next  = 1'b0;
    clear_counters     = 1'b0;
    finish             = 1'b0;
    finish_time        = '0;

    case (state_reg)
      ST_IDLE, ST_DONE, ST_FALSE_START: begin
        if (press) begin
          state_next        = ST_WAIT;
          delay_target_next = new_target;
          clear_counters    = 1'b1;
        end
      end
      ST_WAIT: begin
        if (press) begin
          state_next = ST_FALSE_START;
        end else if (ms_count_reg == delay_target_reg) begin
          state_next     = ST_ARMED;
          clear_counters = 1'b1;
        end else if (ms_tick) begin
          ms_count_next = ms_count_reg + 14'd1;
        end
      end
      ST_ARMED: begin
        // The press captures the count before any same-cycle tick lands.
        if (press) begin
          finish      = 1'b1;
          finish_time = ms_count_reg;
        end else if (ms_count_reg == MAX_TIME) begin
          finish      = 1'b1;
          finish_time = MAX_TIME;
        end else if (ms_tick) begin
          ms_count_next = ms_count_reg + 14'd1;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    if (finish) begin
      state_next         = ST_DONE;
      reaction_time_next = finish_time;
      result_valid_next  = 1'b1;
      if (finish_time < best_time_reg) begin
        best_time_next = finish_time;
      end
    end

    if (clear_counters) begin
      ms_count_next = '0;
    end
  end

  // Datapath registers: counters, captured times and the result pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      presc_reg         <= '0;
      ms_count_reg      <= '0;
      delay_target_reg  <= '0;
      reaction_time_reg <= '0;
      best_time_reg     <= MAX_TIME;
      result_valid_reg  <= 1'b0;
    end else begin
      if (clear_counters || ms_tick) begin
        presc_reg <= '0;
      end else begin
        presc_reg <= presc_reg + PW'(1);
      end
      ms_count_reg      <= ms_count_next;
      delay_target_reg  <= delay_target_next;
      reaction_time_reg <= reaction_time_next;
      best_time_reg     <= best_time_next;
      result_valid_reg  <= result_valid_next;
    end
  end

  // Edge-detect history and the free-running LFSR (reloaded if it ever locks at 0).
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_button_reg <= 1'b1;
      lfsr_reg        <= LFSR_SEED;
    end else begin
      prev_button_reg <= bus.debouncedButton;
      lfsr_reg        <= (lfsr_reg == 16'h0000) ? LFSR_SEED : lfsr_shift;
    end
  end

  assign bus.stimulusLed  = (state_reg == ST_ARMED);
  assign bus.falseStart   = (state_reg == ST_FALSE_START);
  assign bus.busy         = (state_reg == ST_WAIT) || (state_reg == ST_ARMED);
  assign bus.reactionTime = reaction_time_reg;
  assign bus.resultValid  = result_valid_reg;
  assign bus.bestTime     = best_time_reg;

endmodule
